riscv_hazard_unit: RTL and testbench
====================================

# riscv_hazard_unit

Parametrised hazard and forwarding controller for the RV32I pipeline core.
- Keeps a shadow shift register of the destination registers of instructions already issued past ID.
- Produces forwarding selects, load-use stalls and taken-branch flushes.
- Counts stall and flush events.
- Sits beside the ID stage. Its outputs drive the IF/ID and ID/EX pipeline-register enables and clears, and the EX operand muxes, which turns the forwarding-free pipeline into a hazard-safe one.

## Interface
Parameters:
- REG_BITS, 5, register-number width
- FWD_STAGES, 3, tracked stages ahead of ID (1=EX, 2=MEM, 3=WB); legal 1..7
- LOAD_LAT, 1, stages a load needs before its data can be forwarded; legal 1..FWD_STAGES-1
- CNT_W, 32, perf-counter width

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- ID_VALID  in  1  instruction in ID is real
- ID_RS1, ID_RS2  in  REG_BITS  source registers of ID instruction
- ID_USE_RS1, ID_USE_RS2  in  1  source is actually read
- ID_RD  in  REG_BITS  destination of ID instruction
- ID_REGWRITE  in  1  ID instruction writes rd
- ID_ISLOAD  in  1  ID instruction is a load
- EX_BRANCH_TAKEN  in  1  taken branch/jump resolved in EX this cycle
- STALL_IF, STALL_ID  out  1  hold PC and IF/ID register
- FLUSH_FD, FLUSH_DE  out  1  clear IF/ID and ID/EX registers to bubble
- FWD_SEL1, FWD_SEL2  out  FW=$clog2(FWD_STAGES+1)  0 = register file, k = forward from stage k
- STALL_CNT, FLUSH_CNT  out  CNT_W  event counters

## Operation
Shadow entry k (1..FWD_STAGES): {valid, rd, regwrite, isload}.

Shifting:
- Each edge, entry k+1 <= entry k. The back end never stalls.
- Entry 1 <= ID fields with valid=ID_VALID when no stall and no flush; otherwise entry 1 <= bubble (valid=0).

Match(k, rs): entry k valid & regwrite & rd==rs & rd!=0.

Forwarding:
- FWD_SELn = smallest k with Match(k, ID_RSn); 0 if there is no match or ID_USE_RSn=0.
- The youngest producer wins.

Load-use:
- Hazard when ID_VALID & ∃k≤LOAD_LAT: entry k isload & Match(k, used rs).
- On a hazard: STALL_IF=STALL_ID=1 and FLUSH_DE=1, so a bubble enters EX.

Branch:
- EX_BRANCH_TAKEN=1 → FLUSH_FD=FLUSH_DE=1 and STALL_IF=STALL_ID=0.
- The branch has priority over a load-use hazard in the same cycle.
- Entry 1 gets a bubble; the ID instruction is killed.

Counters:
- STALL_CNT +1 per cycle with a load-use stall asserted (not overridden by a branch).
- FLUSH_CNT +1 per taken branch.
- Both wrap modulo 2^CNT_W.

x0: rd=0 never matches, so FWD_SEL stays 0.

## Timing
- All hazard/forward outputs are combinational from ID inputs, EX_BRANCH_TAKEN and registered shadow state, valid in the same cycle.
- Shadow register and counters update on the rising CLK edge.
- Load-use stall duration: exactly LOAD_LAT-k+1 cycles for a matching load at entry k. For the default, 1 cycle when the load is in EX.
- After the stall the same ID instruction sees the load at entry LOAD_LAT+1 and gets FWD_SEL=LOAD_LAT+1.

Reset (RSTN low, async):
- All shadow valids and counters go to 0.
- STALL_*, FLUSH_*, FWD_SEL* go to 0 immediately.
- Reset asserted mid-stall or mid-flush aborts the event; on the first edge after release the unit reports no hazards.

ID_VALID=0: no stall is raised, and FWD_SEL outputs are still computed (don't-care downstream).

## Test plan
- add x5 at ID, then x5 read at ID next cycle → FWD_SEL1=1. Two cycles later → 2. Three cycles later → 3. Four cycles later → 0.
- lw x7 followed directly by add x8,x7,x7 → STALL_IF=STALL_ID=FLUSH_DE=1 for 1 cycle, then FWD_SEL1=FWD_SEL2=2, STALL_CNT=1.
- lw x7 with the consumer two instructions later → no stall, FWD_SEL1=2.
- Load-use hazard and EX_BRANCH_TAKEN in the same cycle → FLUSH_FD=FLUSH_DE=1, STALL_*=0, FLUSH_CNT=1, STALL_CNT unchanged.
- Writes to x0 at entries 1..3 with ID_RS1=0 → FWD_SEL1=0. Producers of x9 at entries 1 and 2 → FWD_SEL=1.
- RSTN low during a load-use stall → outputs 0 immediately, counters 0. After release, the same ID stimulus with no preceding load gives no stall.

Source files
------------

// File: rtl/riscv_hazard_unit.sv
// Hazard and forwarding controller for the RV32I pipeline: tracks destinations of
// instructions past ID, selects forwarding sources, raises load-use stalls and branch flushes.
module riscv_hazard_unit #(
  parameter  int unsigned REG_BITS   = 5,
  parameter  int unsigned FWD_STAGES = 3,
  parameter  int unsigned LOAD_LAT   = 1,
  parameter  int unsigned CNT_W      = 32,
  localparam int unsigned FW         = $clog2(FWD_STAGES + 1)
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                ID_VALID,
  input  logic [REG_BITS-1:0] ID_RS1,
  input  logic [REG_BITS-1:0] ID_RS2,
  input  logic                ID_USE_RS1,
  input  logic                ID_USE_RS2,
  input  logic [REG_BITS-1:0] ID_RD,
  input  logic                ID_REGWRITE,
  input  logic                ID_ISLOAD,
  input  logic                EX_BRANCH_TAKEN,
  output logic                STALL_IF,
  output logic                STALL_ID,
  output logic                FLUSH_FD,
  output logic                FLUSH_DE,
  output logic [FW-1:0]       FWD_SEL1,
  output logic [FW-1:0]       FWD_SEL2,
  output logic [CNT_W-1:0]    STALL_CNT,
  output logic [CNT_W-1:0]    FLUSH_CNT
);

  logic [FWD_STAGES:1] r_valid;
  logic [FWD_STAGES:1] r_rw;
  logic [FWD_STAGES:1] r_ld;
  logic [REG_BITS-1:0] r_rd [1:FWD_STAGES];
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic [FWD_STAGES:1] w_live;
  logic [FWD_STAGES:1] w_m1;
  logic [FWD_STAGES:1] w_m2;
  logic [FWD_STAGES:1] w_luv;
  logic [FW-1:0]       w_sel1 [1:FWD_STAGES+1];
  logic [FW-1:0]       w_sel2 [1:FWD_STAGES+1];
  logic                w_lu;
  logic                w_stall;
  logic                w_bubble;

  assign w_sel1[FWD_STAGES+1] = '0;
  assign w_sel2[FWD_STAGES+1] = '0;

  for (genvar k = 1; k <= FWD_STAGES; k++) begin : g_stage
    assign w_live[k] = r_valid[k] & r_rw[k] & (r_rd[k] != '0);
    assign w_m1[k]   = w_live[k] & ID_USE_RS1 & (r_rd[k] == ID_RS1);
    assign w_m2[k]   = w_live[k] & ID_USE_RS2 & (r_rd[k] == ID_RS2);
    // Chain runs from the oldest stage toward entry 1 so the youngest producer wins.
    assign w_sel1[k] = w_m1[k] ? FW'(k) : w_sel1[k+1];
    assign w_sel2[k] = w_m2[k] ? FW'(k) : w_sel2[k+1];

    if (k <= LOAD_LAT) begin : g_lu
      assign w_luv[k] = r_ld[k] & (w_m1[k] | w_m2[k]);
    end else begin : g_nolu
      assign w_luv[k] = 1'b0;
    end
  end

  assign w_lu     = ID_VALID & (|w_luv);
  assign w_stall  = w_lu & ~EX_BRANCH_TAKEN;
  assign w_bubble = w_lu | EX_BRANCH_TAKEN;

  always_comb begin
    STALL_IF = 1'b0;
    STALL_ID = 1'b0;
    FLUSH_FD = 1'b0;
    FLUSH_DE = 1'b0;
    FWD_SEL1 = '0;
    FWD_SEL2 = '0;
    // Outputs are forced quiet while reset is held, independent of the inputs.
    if (RSTN) begin
      if (EX_BRANCH_TAKEN) begin
        FLUSH_FD = 1'b1;
        FLUSH_DE = 1'b1;
      end else if (w_lu) begin
        STALL_IF = 1'b1;
        STALL_ID = 1'b1;
        FLUSH_DE = 1'b1;
      end
      FWD_SEL1 = w_sel1[1];
      FWD_SEL2 = w_sel2[1];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_valid[1] <= 1'b0;
      r_rw[1]    <= 1'b0;
      r_ld[1]    <= 1'b0;
      r_rd[1]    <= '0;
    end else begin
      r_valid[1] <= ID_VALID & ~w_bubble;
      r_rw[1]    <= ID_REGWRITE;
      r_ld[1]    <= ID_ISLOAD;
      r_rd[1]    <= ID_RD;
    end
  end

  for (genvar k = 2; k <= FWD_STAGES; k++) begin : g_shift
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        r_valid[k] <= 1'b0;
        r_rw[k]    <= 1'b0;
        r_ld[k]    <= 1'b0;
        r_rd[k]    <= '0;
      end else begin
        r_valid[k] <= r_valid[k-1];
        r_rw[k]    <= r_rw[k-1];
        r_ld[k]    <= r_ld[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall)         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (EX_BRANCH_TAKEN) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign STALL_CNT = r_stall_cnt;
  assign FLUSH_CNT = r_flush_cnt;

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Self-checking bench for riscv_hazard_unit: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a behavioural model.
module tb_riscv_hazard_unit;
  localparam int FS = 3;
  localparam int LL = 1;
  localparam int CW = 6;
  localparam int RB = 5;
  localparam int FW = 2;

  logic          clk, rstn;
  logic          id_valid, use1, use2, rw, ld, br;
  logic [RB-1:0] rs1, rs2, rd;
  logic          stall_if, stall_id, flush_fd, flush_de;
  logic [FW-1:0] fwd1, fwd2;
  logic [CW-1:0] stall_cnt, flush_cnt;

  riscv_hazard_unit #(.REG_BITS(RB), .FWD_STAGES(FS), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .CLK(clk), .RSTN(rstn), .ID_VALID(id_valid), .ID_RS1(rs1), .ID_RS2(rs2),
    .ID_USE_RS1(use1), .ID_USE_RS2(use2), .ID_RD(rd), .ID_REGWRITE(rw),
    .ID_ISLOAD(ld), .EX_BRANCH_TAKEN(br), .STALL_IF(stall_if), .STALL_ID(stall_id),
    .FLUSH_FD(flush_fd), .FLUSH_DE(flush_de), .FWD_SEL1(fwd1), .FWD_SEL2(fwd2),
    .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: list of instructions issued past ID, index 1 = youngest (EX).
  bit          mv  [1:FS];
  bit [RB-1:0] mrd [1:FS];
  bit          mrw [1:FS];
  bit          mld [1:FS];
  int unsigned mstall, mflush;

  function automatic void model_reset();
    for (int k = 1; k <= FS; k++) begin
      mv[k] = 0; mrd[k] = 0; mrw[k] = 0; mld[k] = 0;
    end
    mstall = 0;
    mflush = 0;
  endfunction

  function automatic bit m_match(int k, bit [RB-1:0] rs);
    return mv[k] && mrw[k] && (mrd[k] == rs) && (mrd[k] != 0);
  endfunction

  function automatic int m_fwd(bit [RB-1:0] rs, bit u);
    if (!u) return 0;
    for (int k = 1; k <= FS; k++)
      if (m_match(k, rs)) return k;
    return 0;
  endfunction

  function automatic bit m_loaduse();
    if (!id_valid) return 0;
    for (int k = 1; k <= LL; k++)
      if (mld[k] && ((use1 && m_match(k, rs1)) || (use2 && m_match(k, rs2)))) return 1;
    return 0;
  endfunction

  task automatic compare_all();
    bit lu, b, on;
    lu = m_loaduse();
    b  = br;
    on = rstn;
    chk("stall_if",  stall_if,  on && lu && !b);
    chk("stall_id",  stall_id,  on && lu && !b);
    chk("flush_fd",  flush_fd,  on && b);
    chk("flush_de",  flush_de,  on && (b || lu));
    chk("fwd_sel1",  fwd1,      on ? m_fwd(rs1, use1) : 0);
    chk("fwd_sel2",  fwd2,      on ? m_fwd(rs2, use2) : 0);
    chk("stall_cnt", stall_cnt, mstall);
    chk("flush_cnt", flush_cnt, mflush);
  endtask

  task automatic model_edge();
    bit lu, b;
    if (!rstn) begin
      model_reset();
      return;
    end
    lu = m_loaduse();
    b  = br;
    if (lu && !b) mstall = (mstall + 1) % (1 << CW);
    if (b)        mflush = (mflush + 1) % (1 << CW);
    for (int k = FS; k >= 2; k--) begin
      mv[k] = mv[k-1]; mrd[k] = mrd[k-1]; mrw[k] = mrw[k-1]; mld[k] = mld[k-1];
    end
    mv[1]  = id_valid && !(lu || b);
    mrd[1] = rd;
    mrw[1] = rw;
    mld[1] = ld;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit [RB-1:0] a1, input bit u1,
                       input bit [RB-1:0] a2, input bit u2, input bit [RB-1:0] d,
                       input bit w, input bit l, input bit b);
    id_valid = v; rs1 = a1; use1 = u1; rs2 = a2; use2 = u2;
    rd = d; rw = w; ld = l; br = b;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    tick();
    rstn = 1'b1;
  endtask

  int ages [4] = '{1, 2, 3, 0};

  initial begin
    rstn = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_stall_if", stall_if, 0);
    chk("reset_fwd1", fwd1, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    tick();
    tick();
    rstn = 1'b1;

    // Forwarding distance from a single ALU producer of x5
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("fwd_age", fwd1, ages[i]);
      tick();
    end

    // lw x7 ; add x8,x7,x7
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 7, 1, 7, 1, 8, 1, 0, 0);
    #1;
    chk("lu_stall_if", stall_if, 1);
    chk("lu_stall_id", stall_id, 1);
    chk("lu_flush_de", flush_de, 1);
    chk("lu_flush_fd", flush_fd, 0);
    tick();
    #1;
    chk("lu_after_stall", stall_if, 0);
    chk("lu_fwd1", fwd1, 2);
    chk("lu_fwd2", fwd2, 2);
    chk("lu_stall_cnt", stall_cnt, 1);
    tick();

    // Reset asserted in the middle of a load-use stall
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 7, 1, 7, 1, 8, 1, 0, 0);
    #1;
    chk("rst_pre_stall", stall_if, 1);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_stall_if", stall_if, 0);
    chk("rst_stall_id", stall_id, 0);
    chk("rst_flush_de", flush_de, 0);
    chk("rst_fwd1", fwd1, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    tick();
    rstn = 1'b1;
    #1;
    chk("rst_release_stall", stall_if, 0);
    chk("rst_release_flush", flush_de, 0);
    tick();

    // Load consumer two instructions later
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("far_load_stall", stall_if, 0);
    chk("far_load_fwd1", fwd1, 2);
    tick();

    // Branch coincident with a load-use hazard
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick();
    drive(1, 7, 1, 0, 0, 8, 1, 0, 1);
    #1;
    chk("br_flush_fd", flush_fd, 1);
    chk("br_flush_de", flush_de, 1);
    chk("br_stall_if", stall_if, 0);
    chk("br_stall_id", stall_id, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 0);
    tick();

    // x0 producers never forward; the youngest x9 producer wins
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
      tick();
    end
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
    #1;
    chk("x0_fwd1", fwd1, 0);
    chk("x0_fwd2", fwd2, 0);
    tick();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0);
    tick();
    tick();
    drive(1, 9, 1, 9, 1, 0, 0, 0, 0);
    #1;
    chk("x9_fwd1", fwd1, 1);
    chk("x9_fwd2", fwd2, 1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 1999) == 0) begin
        rstn = 1'b0;
        model_reset();
      end else begin
        rstn = 1'b1;
      end
      drive(($urandom % 8) != 0, RB'($urandom_range(0, 3)), ($urandom % 4) != 0,
            RB'($urandom_range(0, 3)), ($urandom % 4) != 0, RB'($urandom_range(0, 3)),
            ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 10) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
